// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU (op 0 = add, op 1 = subtract magnitude)
// between two requesters. Round-robin grant in IDLE, operands latched on
// acceptance, one EXEC cycle for the ALU to settle, then a registered
// response held in RESP until the consumer takes it.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   reqX_valid/a/b/op          requester X operation (X = 0, 1)
//   reqX_ready                 requester X accepted this cycle (IDLE only)
//   alu_a, alu_b, alu_op       drive the shared ALU
//   alu_r, alu_n/c/v           ALU result and flags
//   rsp_valid, rsp_ready       response handshake
//   rsp_id, rsp_r, rsp_flags   issuing requester, result, {N, Z, C, V}
//   rsp_err                    the opcode was illegal (2..7)
module alu_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic [2:0]   req0_op,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   input  logic [2:0]   req1_op,
   output logic         req1_ready,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [2:0]   alu_op,
   input  logic [N-1:0] alu_r,
   input  logic         alu_n,
   input  logic         alu_c,
   input  logic         alu_v,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [N-1:0] rsp_r,
   output logic [3:0]   rsp_flags,
   output logic         rsp_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t       state_r;
   state_t       state_nxt_s;
   logic         last_grant_r;
   logic [N-1:0] opa_r;
   logic [N-1:0] opb_r;
   logic [2:0]   opop_r;
   logic         opid_r;
   logic         rsp_id_r;
   logic [N-1:0] rsp_r_r;
   logic [3:0]   rsp_flags_r;
   logic         rsp_err_r;
   logic         grant_vld_s;
   logic         grant_id_s;
   logic [2:0]   alu_op_s;

   // Zero flag is derived locally from the ALU result, never from the ALU.
   function automatic logic is_zero(input logic [N-1:0] v);
      return (v == {N{1'b0}});
   endfunction

   // Only add (0) and subtract-magnitude (1) are defined opcodes.
   function automatic logic op_legal(input logic [2:0] op);
      return (op == 3'd0) || (op == 3'd1);
   endfunction

   // Round-robin grant: a lone requester wins, a tie goes to the one not
   // granted last. Masked by rst so ready reads 0 for the whole reset.
   always_comb begin
      grant_vld_s = 1'b0;
      grant_id_s  = 1'b0;
      if ((state_r == IDLE) && !rst) begin
         if (req0_valid && req1_valid) begin
            grant_vld_s = 1'b1;
            grant_id_s  = ~last_grant_r;
         end else if (req0_valid) begin
            grant_vld_s = 1'b1;
            grant_id_s  = 1'b0;
         end else if (req1_valid) begin
            grant_vld_s = 1'b1;
            grant_id_s  = 1'b1;
         end else begin
            grant_vld_s = 1'b0;
            grant_id_s  = 1'b0;
         end
      end else begin
         grant_vld_s = 1'b0;
         grant_id_s  = 1'b0;
      end
   end

   assign req0_ready = grant_vld_s & ~grant_id_s;
   assign req1_ready = grant_vld_s &  grant_id_s;

   // Next-state logic: IDLE -> EXEC on accept, EXEC always one cycle,
   // RESP waits for the consumer.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant_vld_s) begin
               state_nxt_s = EXEC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         EXEC: begin
            state_nxt_s = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Operand latch and grant history; last_grant resets to 1 so req0 wins
   // the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_r <= 1'b1;
         opa_r        <= {N{1'b0}};
         opb_r        <= {N{1'b0}};
         opop_r       <= 3'd0;
         opid_r       <= 1'b0;
      end else if (grant_vld_s) begin
         last_grant_r <= grant_id_s;
         opa_r        <= grant_id_s ? req1_a  : req0_a;
         opb_r        <= grant_id_s ? req1_b  : req0_b;
         opop_r       <= grant_id_s ? req1_op : req0_op;
         opid_r       <= grant_id_s;
      end else begin
         last_grant_r <= last_grant_r;
         opa_r        <= opa_r;
         opb_r        <= opb_r;
         opop_r       <= opop_r;
         opid_r       <= opid_r;
      end
   end

   // Response capture at the end of EXEC; held untouched through RESP and
   // beyond until the next capture. Illegal opcodes report zero result and
   // flags with the error bit set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_id_r    <= 1'b0;
         rsp_r_r     <= {N{1'b0}};
         rsp_flags_r <= 4'd0;
         rsp_err_r   <= 1'b0;
      end else if (state_r == EXEC) begin
         rsp_id_r <= opid_r;
         if (op_legal(opop_r)) begin
            rsp_r_r     <= alu_r;
            rsp_flags_r <= {alu_n, is_zero(alu_r), alu_c, alu_v};
            rsp_err_r   <= 1'b0;
         end else begin
            rsp_r_r     <= {N{1'b0}};
            rsp_flags_r <= 4'd0;
            rsp_err_r   <= 1'b1;
         end
      end else begin
         rsp_id_r    <= rsp_id_r;
         rsp_r_r     <= rsp_r_r;
         rsp_flags_r <= rsp_flags_r;
         rsp_err_r   <= rsp_err_r;
      end
   end

   // ALU opcode is live only during EXEC and only for a legal opcode.
   always_comb begin
      alu_op_s = 3'd0;
      if ((state_r == EXEC) && op_legal(opop_r)) begin
         alu_op_s = opop_r;
      end else begin
         alu_op_s = 3'd0;
      end
   end

   assign alu_a     = opa_r;
   assign alu_b     = opb_r;
   assign alu_op    = alu_op_s;
   assign rsp_valid = (state_r == RESP);
   assign rsp_id    = rsp_id_r;
   assign rsp_r     = rsp_r_r;
   assign rsp_flags = rsp_flags_r;
   assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (N = 4). Provides a behavioural ALU,
// runs a table of directed transactions, hand-written reset sequences and
// randomized transactions checked against an arithmetic reference model.
module tb_alu_arbiter;

   localparam int N = 4;
   localparam int M = 1 << N;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req1_valid;
   logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]   req0_op, req1_op;
   logic         req0_ready, req1_ready;
   logic [N-1:0] alu_a, alu_b, alu_r;
   logic [2:0]   alu_op;
   logic         alu_n, alu_c, alu_v;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [N-1:0] rsp_r;
   logic [3:0]   rsp_flags;

   int n_checks = 0;
   int n_pass   = 0;
   logic last_g;

   always #5 clk = ~clk;

   alu_arbiter #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .req1_ready(req1_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_r(alu_r), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_r(rsp_r), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
   );

   // Behavioural ALU: add gives carry and signed overflow, sub gives the
   // magnitude with N and C both meaning a < b.
   logic [N:0] sum5;
   always_comb begin
      sum5  = {1'b0, alu_a} + {1'b0, alu_b};
      alu_r = '0; alu_n = 1'b0; alu_c = 1'b0; alu_v = 1'b0;
      if (alu_op == 3'd0) begin
         alu_r = sum5[N-1:0];
         alu_c = sum5[N];
         alu_v = (alu_a[N-1] == alu_b[N-1]) && (sum5[N-1] != alu_a[N-1]);
      end else if (alu_op == 3'd1) begin
         alu_r = (alu_a >= alu_b) ? alu_a - alu_b : alu_b - alu_a;
         alu_n = (alu_a < alu_b);
         alu_c = (alu_a < alu_b);
      end else begin
         alu_r = 4'hA;     // garbage: must never reach a response
         alu_n = 1'b1;
         alu_c = 1'b1;
         alu_v = 1'b1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model from the arithmetic rules, using plain integers.
   task automatic ref_model(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op,
                            output logic [N-1:0] r, output logic [3:0] f, output logic e);
      int ia, ib, full, sa, sb, ss, res;
      ia = int'(a); ib = int'(b);
      if (op == 3'd0) begin
         full = ia + ib;
         res  = full % M;
         sa   = (ia >= M/2) ? ia - M : ia;
         sb   = (ib >= M/2) ? ib - M : ib;
         ss   = sa + sb;
         r    = res[N-1:0];
         f    = {1'b0, res == 0, full >= M, (ss > M/2 - 1) || (ss < -(M/2))};
         e    = 1'b0;
      end else if (op == 3'd1) begin
         res = (ia >= ib) ? ia - ib : ib - ia;
         r   = res[N-1:0];
         f   = {ia < ib, res == 0, ia < ib, 1'b0};
         e   = 1'b0;
      end else begin
         r = '0; f = 4'd0; e = 1'b1;
      end
   endtask

   // One full transaction starting at posedge+1 in IDLE; returns at
   // posedge+1 back in IDLE. bp = cycles rsp_ready is held low in RESP.
   task automatic run_txn(input logic v0, input logic v1,
                          input logic [N-1:0] a0, input logic [N-1:0] b0, input logic [2:0] op0,
                          input logic [N-1:0] a1, input logic [N-1:0] b1, input logic [2:0] op1,
                          input int bp, input logic eid, input logic [N-1:0] er,
                          input logic [3:0] ef, input logic ee);
      logic [N-1:0] ea, eb;
      logic [2:0]   eop;
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
      ea  = eid ? a1 : a0;
      eb  = eid ? b1 : b0;
      eop = eid ? op1 : op0;
      @(negedge clk);
      check("idle_ready0", {31'd0, req0_ready}, {31'd0, !eid});
      check("idle_ready1", {31'd0, req1_ready}, {31'd0, eid});
      check("idle_alu_op", {29'd0, alu_op}, 32'd0);
      @(posedge clk); #1;
      last_g = eid;
      @(negedge clk);
      check("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      check("exec_alu_a", {28'd0, alu_a}, {28'd0, ea});
      check("exec_alu_b", {28'd0, alu_b}, {28'd0, eb});
      check("exec_alu_op", {29'd0, alu_op}, (eop <= 3'd1) ? {29'd0, eop} : 32'd0);
      @(posedge clk); #1;
      for (int k = 0; k <= bp; k++) begin
         @(negedge clk);
         check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
         check("rsp_id", {31'd0, rsp_id}, {31'd0, eid});
         check("rsp_r", {28'd0, rsp_r}, {28'd0, er});
         check("rsp_flags", {28'd0, rsp_flags}, {28'd0, ef});
         check("rsp_err", {31'd0, rsp_err}, {31'd0, ee});
         check("resp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
         check("resp_alu_op", {29'd0, alu_op}, 32'd0);
         rsp_ready = (k == bp);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b0;
   endtask

   typedef struct {
      logic v0, v1;
      logic [N-1:0] a0, b0; logic [2:0] op0;
      logic [N-1:0] a1, b1; logic [2:0] op1;
      int bp;
      logic eid; logic [N-1:0] er; logic [3:0] ef; logic ee;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic          v0, v1, eid, ee;
      logic [N-1:0]  a0, b0, a1, b1, er;
      logic [2:0]    op0, op1;
      logic [3:0]    ef;

      // Directed vectors; expected values worked out by hand. V follows the
      // bench ALU (signed overflow on add, 0 on sub).
      vecs[0] = '{1'b1, 1'b0, 4'd3, 4'd5, 3'd0, 4'd0, 4'd0, 3'd0, 0, 1'b0, 4'd8, 4'b0001, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 4'd9, 4'd7, 3'd0, 4'd0, 4'd0, 3'd0, 0, 1'b0, 4'd0, 4'b0110, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 4'd0, 4'd0, 3'd0, 4'd2, 4'd5, 3'd1, 4, 1'b1, 4'd3, 4'b1010, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 4'd0, 4'd0, 3'd0, 4'd5, 4'd5, 3'd1, 0, 1'b1, 4'd0, 4'b0100, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 4'd6, 4'd3, 3'd5, 4'd0, 4'd0, 3'd0, 1, 1'b0, 4'd0, 4'b0000, 1'b1};
      vecs[5] = '{1'b1, 1'b1, 4'd1, 4'd2, 3'd0, 4'd7, 4'd4, 3'd1, 0, 1'b1, 4'd3, 4'b0000, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 4'd1, 4'd2, 3'd0, 4'd7, 4'd4, 3'd1, 0, 1'b0, 4'd3, 4'b0000, 1'b0};

      // Reset with req0 pending: everything quiet while rst is high.
      rst = 1'b1; rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2; req0_op = 3'd0;
      req1_valid = 1'b0; req1_a = '0;   req1_b = '0;   req1_op = 3'd0;
      last_g = 1'b1;
      #7;
      check("rst_ready0", {31'd0, req0_ready}, 32'd0);
      check("rst_ready1", {31'd0, req1_ready}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_alu", {21'd0, alu_op, alu_a, alu_b}, 32'd0);
      check("rst_rsp", {22'd0, rsp_id, rsp_err, rsp_flags, rsp_r}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Contention from reset: alternating grants starting with req0.
      for (int i = 0; i < 4; i++) begin
         a0 = 4'(i + 1); b0 = 4'd1; a1 = 4'(i + 8); b1 = 4'd2;
         eid = ~last_g;
         ref_model(eid ? a1 : a0, eid ? b1 : b0, eid ? 3'd1 : 3'd0, er, ef, ee);
         check("contention_order", {31'd0, eid}, {31'd0, 1'(i % 2)});
         run_txn(1'b1, 1'b1, a0, b0, 3'd0, a1, b1, 3'd1, 0, eid, er, ef, ee);
      end

      // Directed table (last grant is req1 here, so req0 goes first).
      for (int i = 0; i < 7; i++) begin
         run_txn(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].b0, vecs[i].op0,
                 vecs[i].a1, vecs[i].b1, vecs[i].op1, vecs[i].bp,
                 vecs[i].eid, vecs[i].er, vecs[i].ef, vecs[i].ee);
      end

      // Reset while in RESP with req0 pending.
      req0_valid = 1'b1; req1_valid = 1'b0; req0_a = 4'd4; req0_b = 4'd4; req0_op = 3'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #2;
      check("pre_rst_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("midrst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      check("midrst_alu_op", {29'd0, alu_op}, 32'd0);
      last_g = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      run_txn(1'b1, 1'b1, 4'd2, 4'd3, 3'd0, 4'd6, 4'd1, 3'd1, 0, 1'b0, 4'd5, 4'b0000, 1'b0);

      // Reset during EXEC: transaction discarded, last grant back to 1.
      req0_valid = 1'b1; req1_valid = 1'b0; req0_a = 4'd7; req0_b = 4'd1; req0_op = 3'd1;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      #2;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      last_g = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
         @(posedge clk); #1;
      end
      run_txn(1'b1, 1'b1, 4'd1, 4'd1, 3'd0, 4'd3, 4'd3, 3'd1, 0, 1'b0, 4'd2, 4'b0000, 1'b0);

      // Randomized transactions against the reference model.
      for (int i = 0; i < 40; i++) begin
         v0  = 1'($urandom_range(0, 1));
         v1  = 1'($urandom_range(0, 1));
         a0  = 4'($urandom_range(0, M - 1)); b0 = 4'($urandom_range(0, M - 1));
         a1  = 4'($urandom_range(0, M - 1)); b1 = 4'($urandom_range(0, M - 1));
         op0 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
         op1 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
         if (!v0 && !v1) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            @(negedge clk);
            check("rand_idle_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            check("rand_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            @(posedge clk); #1;
         end else begin
            eid = (v0 && v1) ? ~last_g : !v0;
            ref_model(eid ? a1 : a0, eid ? b1 : b0, eid ? op1 : op0, er, ef, ee);
            run_txn(v0, v1, a0, b0, op0, a1, b1, op1, int'($urandom_range(0, 2)), eid, er, ef, ee);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
